pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard, forwarding and flush controller for the in-order RV32I pipeline; replaces the fixed two-stage forwarding unit and one-cycle load-use detector. Internally tracks every in-flight instruction from EX to WB in a valid/rd shift register. From that it produces forward selects, load-use stalls for any load latency, and branch flushes for any branch-resolve stage. Sits beside the ID/EX register; the pipeline top drives it from ID-stage decode and the branch-resolve stage.

Parameters:
REG_ADDR_W, 5, register index width
FWD_STAGES, 2, stages after EX that can forward (1 = MEM ... FWD_STAGES = WB); range 1..6
LOAD_LAT, 1, slot index after EX where load data first becomes forwardable minus 1; requires LOAD_LAT+1 <= FWD_STAGES
BRANCH_STAGE, 1, slot index (0 = EX) where branch_taken is resolved; range 0..FWD_STAGES
FWD_W, $clog2(FWD_STAGES+1), forward select width (derived, do not override)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
id_use_rs1, id_use_rs2  in  1  source actually read
id_rd  in  REG_ADDR_W  ID destination
id_regwrite  in  1  ID instruction writes rd
id_memread  in  1  ID instruction is a load
branch_taken  in  1  taken branch/jump resolved in slot BRANCH_STAGE
forward_a, forward_b  out  FWD_W  0 = register file, k = result of slot k
pipeline_stall  out  1  insert bubble into EX, hold IF/ID
pc_write  out  1  PC enable
if_id_write  out  1  IF/ID enable
flush  out  1  squash IF/ID and all stages younger than BRANCH_STAGE

Behaviour:
- State: slots 0..FWD_STAGES; each holds {valid, rd, regwrite, memread, rs1, rs2, use_rs1, use_rs2}. Slot 0 = EX.
- Reset (reset low, async): all slots invalid. Outputs follow combinationally: forward_a/b=0, pipeline_stall=0, pc_write=1, if_id_write=1, flush=0. Reset mid-operation discards all tracking. First edge after release starts clean.
- Each posedge: slot k+1 <= slot k for all k. Slot 0 <= ID fields with valid = id_valid & ~pipeline_stall & ~flush.
- Flush: when branch_taken=1, slots 0..BRANCH_STAGE-1 are marked invalid as they shift. flush=1 combinationally in the same cycle. pc_write stays 1 so the PC can load the target.
- Load-use stall (combinational): asserted when id_valid, and for a used rs != 0 some slot j < LOAD_LAT is valid with memread=1 and rd == rs. Also requires flush=0.
- During a stall: pipeline_stall=1, pc_write=0, if_id_write=0, and a bubble enters slot 0.
- Priority: flush overrides stall. A stall in a branch_taken cycle is suppressed.
- Forwarding (combinational, for slot 0): forward_a is the lowest k in 1..FWD_STAGES where slot k is valid, regwrite=1, rd != 0 and rd == slot0.rs1 with use_rs1=1; otherwise 0. forward_b is the same for rs2.
- Forwarding outputs are 0 when slot 0 is invalid. Youngest producer wins.
- x0 never forwards and never stalls.
- Invariant (bench assertion): no selected forward source k is a load with k < LOAD_LAT+1.
- No internal latency beyond the slot shift; all outputs are combinational from state and ID inputs.

Optional Feature:
HAZARD_PERF_EN: adds outputs stall_count[31:0] and flush_count[31:0].
- Counts cycles with pipeline_stall=1 and with flush=1 respectively.
- Both saturate at 32'hFFFFFFFF and clear on reset.
- Without the macro the ports and counters do not exist.

Decomposition:
- Shared package: slot struct typedef, FWD_SEL_RF=0 constant, and a parameter legality check function (LOAD_LAT+1 <= FWD_STAGES, BRANCH_STAGE <= FWD_STAGES).
- One natural sub-module, hazard_fwd_match: the per-operand priority comparator, instantiated twice (rs1, rs2).

Test Plan:
- Defaults; ALU op rd=x5, then consumer rs1=x5 -> next cycle forward_a=1; one instruction later forward_a=2; x0 as dest -> forward_a=0.
- Defaults; load rd=x7 in EX, ID uses rs2=x7 -> pipeline_stall=1, pc_write=0, if_id_write=0 for one cycle; consumer then in EX with forward_b=2.
- LOAD_LAT=2, FWD_STAGES=3; load rd=x3 then immediate consumer -> exactly 2 stall cycles, then forward_a=3.
- Defaults; branch_taken=1 while ID has a load-use hazard -> flush=1, pipeline_stall=0, pc_write=1; next cycle slots 0 and 1 invalid, forward_a/b=0.
- Writes to x9 in slots 1 and 2, EX reads x9 -> forward_a=1 (youngest wins).
- reset pulled low for 3 ns mid-stream (async, between edges) -> outputs immediately at reset values; after release no stale forwarding; with HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned SLOT_REG_W = 8;
    localparam int unsigned FWD_SEL_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_REG_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic [SLOT_REG_W-1:0] rs1;
        logic [SLOT_REG_W-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } hazard_slot_t;

    // Legal configurations: load data must surface inside the forwarding window.
    function automatic bit hazard_params_ok(input int unsigned reg_addr_w,
                                            input int unsigned fwd_stages,
                                            input int unsigned load_lat,
                                            input int unsigned branch_stage);
        return (reg_addr_w >= 1) && (reg_addr_w <= SLOT_REG_W) &&
               (fwd_stages >= 1) && (fwd_stages <= 6) &&
               (load_lat + 1 <= fwd_stages) &&
               (branch_stage <= fwd_stages);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_match.sv
// Per-operand forward select: youngest valid producer of the EX source register.
module hazard_fwd_match
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned FWD_W      = $clog2(FWD_STAGES + 1)
) (
    input  hazard_slot_t [FWD_STAGES:0] slots,
    input  logic [SLOT_REG_W-1:0]       rs,
    input  logic                        use_rs,
    output logic [FWD_W-1:0]            sel_c
);

    // Only a few slot fields feed the comparator; the rest are tied off here.
    logic unused_slot_bits;
    assign unused_slot_bits = ^slots;

    // Scan oldest to youngest so the lowest matching slot is the one kept.
    always_comb begin
        sel_c = FWD_W'(FWD_SEL_RF);
        if (slots[0].valid && use_rs && (rs != '0)) begin
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (slots[k].valid && slots[k].regwrite && (slots[k].rd == rs)) begin
                    sel_c = FWD_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and flush controller tracking in-flight instructions EX..WB.
// Define HAZARD_PERF_EN to add saturating stall_count / flush_count outputs.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned FWD_STAGES   = 2,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned BRANCH_STAGE = 1,
    parameter int unsigned FWD_W        = $clog2(FWD_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  branch_taken,
    output logic [FWD_W-1:0]      forward_a,
    output logic [FWD_W-1:0]      forward_b,
    output logic                  pipeline_stall,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
`endif
);

    if (!hazard_params_ok(REG_ADDR_W, FWD_STAGES, LOAD_LAT, BRANCH_STAGE)) begin : g_param_err
        $error("pipeline_hazard_ctrl: illegal parameter combination");
    end

    hazard_slot_t [FWD_STAGES:0] slot_q;
    hazard_slot_t [FWD_STAGES:0] slot_d;

    logic [SLOT_REG_W-1:0] id_rs1_w;
    logic [SLOT_REG_W-1:0] id_rs2_w;
    logic [SLOT_REG_W-1:0] id_rd_w;
    logic                  load_hit_c;
    logic                  flush_c;
    logic                  stall_c;

    assign id_rs1_w = SLOT_REG_W'(id_rs1);
    assign id_rs2_w = SLOT_REG_W'(id_rs2);
    assign id_rd_w  = SLOT_REG_W'(id_rd);

    // Load-use: a load still too young to forward writes a register ID reads.
    always_comb begin
        load_hit_c = 1'b0;
        for (int j = 0; j < int'(LOAD_LAT); j++) begin
            if (slot_q[j].valid && slot_q[j].memread) begin
                if (id_use_rs1 && (id_rs1_w != '0) && (slot_q[j].rd == id_rs1_w)) begin
                    load_hit_c = 1'b1;
                end
                if (id_use_rs2 && (id_rs2_w != '0) && (slot_q[j].rd == id_rs2_w)) begin
                    load_hit_c = 1'b1;
                end
            end
        end
        // Held in reset the controller must look idle even if a branch is signalled.
        flush_c = branch_taken & reset;
        stall_c = id_valid & load_hit_c & ~flush_c;
    end

    // Slot shift; a flush kills everything younger than the resolving branch.
    always_comb begin
        slot_d = slot_q;
        slot_d[0].valid    = id_valid & ~stall_c & ~flush_c;
        slot_d[0].rd       = id_rd_w;
        slot_d[0].regwrite = id_regwrite;
        slot_d[0].memread  = id_memread;
        slot_d[0].rs1      = id_rs1_w;
        slot_d[0].rs2      = id_rs2_w;
        slot_d[0].use_rs1  = id_use_rs1;
        slot_d[0].use_rs2  = id_use_rs2;
        for (int k = 1; k <= int'(FWD_STAGES); k++) begin
            slot_d[k] = slot_q[k-1];
            if (flush_c && ((k - 1) < int'(BRANCH_STAGE))) begin
                slot_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    hazard_fwd_match #(
        .FWD_STAGES (FWD_STAGES),
        .FWD_W      (FWD_W)
    ) u_fwd_a (
        .slots  (slot_q),
        .rs     (slot_q[0].rs1),
        .use_rs (slot_q[0].use_rs1),
        .sel_c  (forward_a)
    );

    hazard_fwd_match #(
        .FWD_STAGES (FWD_STAGES),
        .FWD_W      (FWD_W)
    ) u_fwd_b (
        .slots  (slot_q),
        .rs     (slot_q[0].rs2),
        .use_rs (slot_q[0].use_rs2),
        .sel_c  (forward_b)
    );

    assign pipeline_stall = stall_c;
    assign pc_write       = ~stall_c;
    assign if_id_write    = ~stall_c;
    assign flush          = flush_c;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;
    logic [31:0] flush_count_q;
    logic [31:0] flush_count_d;

    // Saturating event counters.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_c && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (flush_c && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
